// File: rtl/sdram_init_monitor_if.sv
// SDRAM command/address pins as seen at the device.
// The controller drives the pins through the master modport. The monitor only listens through the slave modport.
interface sdram_init_monitor_if;
   logic        dram_cs_n;
   logic        dram_ras_n;
   logic        dram_cas_n;
   logic        dram_we_n;
   logic [12:0] dram_addr;
   logic [1:0]  dram_ba;

   modport master (
      output dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_addr, dram_ba
   );

   modport slave (
      input dram_cs_n, dram_ras_n, dram_cas_n, dram_we_n, dram_addr, dram_ba
   );
endinterface

// File: rtl/sdram_init_monitor.sv
// Passive checker for the SDRAM power-up sequence: wait, PALL, auto-refresh burst, MRS.
// Reports completion, the programmed mode word and the first ordering/spacing violation.
module sdram_init_monitor #(
   parameter int POWER_UP_CYCLES = 20000,
   parameter int TRP_CYCLES      = 2,
   parameter int TRC_CYCLES      = 9,
   parameter int REFRESH_COUNT   = 8
) (
   input  logic                     clock,
   input  logic                     reset,
   sdram_init_monitor_if.slave      bus,
   output logic                     init_done,
   output logic                     error,
   output logic [2:0]               error_code,
   output logic [12:0]              mode_reg,
   output logic [2:0]               cas_latency,
   output logic [3:0]               refresh_count
);
   typedef enum logic [1:0] {WAIT_PWR, WAIT_REF, DONE, ERROR} state_t;

   state_t      state_q, state_d;
   logic [14:0] pwr_cnt_q, pwr_cnt_d;
   logic [7:0]  gap_cnt_q, gap_cnt_d;
   logic [3:0]  ref_cnt_q, ref_cnt_d;
   logic [2:0]  code_q, code_d;
   logic [12:0] mode_q, mode_d;

   // Output stage: status becomes visible one edge after the sampling edge.
   logic        init_done_q, init_done_d;
   logic        error_q, error_d;
   logic [2:0]  error_code_q, error_code_d;
   logic [12:0] mode_reg_q, mode_reg_d;
   logic [3:0]  refresh_count_q, refresh_count_d;

   logic [3:0]  cmd;
   logic        is_idle, is_pall, is_ref, is_mrs, a10, mode_ok;
   logic [8:0]  k;
   logic [2:0]  viol;

   always_comb begin
      cmd     = {bus.dram_cs_n, bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n};
      is_idle = cmd[3] | (cmd == 4'b0111);
      is_pall = (cmd == 4'b0010);
      is_ref  = (cmd == 4'b0001);
      is_mrs  = (cmd == 4'b0000);
      a10     = bus.dram_addr[10];
      k       = {1'b0, gap_cnt_q} + 9'd1;
      mode_ok = (bus.dram_ba == 2'd0) && (bus.dram_addr[12:10] == 3'd0) &&
                (bus.dram_addr[8:7] == 2'd0) &&
                ((bus.dram_addr[6:4] == 3'd2) || (bus.dram_addr[6:4] == 3'd3));

      state_d   = state_q;
      pwr_cnt_d = (pwr_cnt_q >= 15'(POWER_UP_CYCLES)) ? pwr_cnt_q : pwr_cnt_q + 15'd1;
      gap_cnt_d = (is_pall || is_ref) ? 8'd0 :
                  (gap_cnt_q == 8'hFF) ? gap_cnt_q : gap_cnt_q + 8'd1;
      ref_cnt_d = ref_cnt_q;
      code_d    = code_q;
      mode_d    = mode_q;
      viol      = 3'd0;

      case (state_q)
         WAIT_PWR: begin
            if (is_pall) begin
               if (!a10)                                   viol = 3'd6;
               else if (pwr_cnt_q < 15'(POWER_UP_CYCLES))  viol = 3'd1;
               else begin
                  state_d   = WAIT_REF;
                  ref_cnt_d = 4'd0;
               end
            end else if (!is_idle) begin
               viol = 3'd6;
            end
         end
         WAIT_REF: begin
            if (is_pall) begin
               if (!a10) viol = 3'd6;
               else      ref_cnt_d = 4'd0;
            end else if (is_ref) begin
               // A zero count means the previous spacing reference is the PALL.
               if ((ref_cnt_q == 4'd0) && (k < 9'(TRP_CYCLES)))      viol = 3'd2;
               else if ((ref_cnt_q != 4'd0) && (k < 9'(TRC_CYCLES))) viol = 3'd3;
               else ref_cnt_d = (ref_cnt_q == 4'hF) ? ref_cnt_q : ref_cnt_q + 4'd1;
            end else if (is_mrs) begin
               if (ref_cnt_q < 4'(REFRESH_COUNT)) viol = 3'd4;
               else if (k < 9'(TRC_CYCLES))       viol = 3'd3;
               else if (!mode_ok)                 viol = 3'd5;
               else begin
                  state_d = DONE;
                  mode_d  = bus.dram_addr;
               end
            end else if (!is_idle) begin
               viol = 3'd6;
            end
         end
         default: ;
      endcase

      if (viol != 3'd0) begin
         state_d   = ERROR;
         code_d    = viol;
         ref_cnt_d = ref_cnt_q;
      end

      init_done_d     = (state_q == DONE);
      error_d         = (state_q == ERROR);
      error_code_d    = code_q;
      mode_reg_d      = mode_q;
      refresh_count_d = ref_cnt_q;
   end

   always_ff @(posedge clock or negedge reset) begin
      if (!reset) begin
         state_q         <= WAIT_PWR;
         pwr_cnt_q       <= '0;
         gap_cnt_q       <= '0;
         ref_cnt_q       <= '0;
         code_q          <= '0;
         mode_q          <= '0;
         init_done_q     <= 1'b0;
         error_q         <= 1'b0;
         error_code_q    <= '0;
         mode_reg_q      <= '0;
         refresh_count_q <= '0;
      end else begin
         state_q         <= state_d;
         pwr_cnt_q       <= pwr_cnt_d;
         gap_cnt_q       <= gap_cnt_d;
         ref_cnt_q       <= ref_cnt_d;
         code_q          <= code_d;
         mode_q          <= mode_d;
         init_done_q     <= init_done_d;
         error_q         <= error_d;
         error_code_q    <= error_code_d;
         mode_reg_q      <= mode_reg_d;
         refresh_count_q <= refresh_count_d;
      end
   end

   assign init_done     = init_done_q;
   assign error         = error_q;
   assign error_code    = error_code_q;
   assign mode_reg      = mode_reg_q;
   assign cas_latency   = mode_reg_q[6:4];
   assign refresh_count = refresh_count_q;
endmodule

// File: tb/tb_sdram_init_monitor.sv
// Bench for sdram_init_monitor: directed scenarios plus randomized init sequences checked
// against an event-time reference model.
`timescale 1ns/1ps
module tb_sdram_init_monitor;
   localparam int PWR  = 100;
   localparam int TRP  = 2;
   localparam int TRC  = 9;
   localparam int NREF = 8;

   localparam logic [3:0] C_NOP  = 4'b0111;
   localparam logic [3:0] C_PALL = 4'b0010;
   localparam logic [3:0] C_REF  = 4'b0001;
   localparam logic [3:0] C_MRS  = 4'b0000;
   localparam logic [3:0] C_ACT  = 4'b0011;

   typedef struct packed {
      logic [3:0]  c;
      logic [12:0] a;
      logic [1:0]  ba;
   } cmd_t;

   logic        clock = 1'b0;
   logic        reset = 1'b1;
   logic        init_done, error;
   logic [2:0]  error_code, cas_latency;
   logic [12:0] mode_reg;
   logic [3:0]  refresh_count;

   sdram_init_monitor_if bus ();

   sdram_init_monitor #(
      .POWER_UP_CYCLES(PWR), .TRP_CYCLES(TRP), .TRC_CYCLES(TRC), .REFRESH_COUNT(NREF)
   ) dut (
      .clock(clock), .reset(reset), .bus(bus),
      .init_done(init_done), .error(error), .error_code(error_code),
      .mode_reg(mode_reg), .cas_latency(cas_latency), .refresh_count(refresh_count)
   );

   always #5 clock = ~clock;

   int   total = 0;
   int   bad   = 0;
   cmd_t seq[$];

   // Status vector: {init_done, error, error_code, mode_reg, cas_latency, refresh_count}
   function automatic logic [24:0] obs();
      return {init_done, error, error_code, mode_reg, cas_latency, refresh_count};
   endfunction

   function automatic logic [24:0] mk(input bit d, input bit e, input logic [2:0] code,
                                      input logic [12:0] mode, input int rc);
      return {d, e, code, mode, mode[6:4], 4'(rc)};
   endfunction

   task automatic push(input logic [3:0] c, input logic [12:0] a, input logic [1:0] ba);
      cmd_t x;
      x.c = c; x.a = a; x.ba = ba;
      seq.push_back(x);
   endtask

   task automatic push_nops(input int n);
      for (int i = 0; i < n; i++) push(C_NOP, 13'($urandom), 2'($urandom));
   endtask

   task automatic push_idle_rand(input int n);
      for (int i = 0; i < n; i++) begin
         if ($urandom_range(0, 1) == 0) push(C_NOP, 13'($urandom), 2'($urandom));
         else push({1'b1, 3'($urandom)}, 13'($urandom), 2'($urandom));
      end
   endtask

   task automatic drive_seq();
      foreach (seq[i]) begin
         {bus.dram_cs_n, bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = seq[i].c;
         bus.dram_addr = seq[i].a;
         bus.dram_ba   = seq[i].ba;
         @(negedge clock);
      end
      seq.delete();
   endtask

   task automatic idle(input int n);
      push_nops(n);
      drive_seq();
   endtask

   task automatic apply_reset();
      reset = 1'b0;
      {bus.dram_cs_n, bus.dram_ras_n, bus.dram_cas_n, bus.dram_we_n} = C_NOP;
      bus.dram_addr = '0;
      bus.dram_ba   = '0;
      repeat (2) @(negedge clock);
      reset = 1'b1;
   endtask

   task automatic legal_prefix(input int nrefs);
      push_nops(PWR);
      push(C_PALL, 13'h400, 2'd0);
      push_nops(2);
      for (int r = 0; r < nrefs; r++) begin
         push(C_REF, 13'h0, 2'd0);
         push_nops(9);
      end
   endtask

   // Reference model: walks the command list with absolute edge indices (index i is
   // sampled while the power-up counter reads i) and applies the rules in check order.
   function automatic logic [24:0] model();
      int          t_pall = -1;
      int          t_ref  = -1;
      int          nref   = 0;
      bit          in_ref = 0;
      bit          done   = 0;
      logic [2:0]  code   = 3'd0;
      logic [12:0] mode   = 13'd0;
      logic [3:0]  c;
      logic [12:0] a;
      for (int i = 0; i < seq.size(); i++) begin
         if (done || code != 3'd0) break;
         c = seq[i].c;
         a = seq[i].a;
         if (c[3] == 1'b1 || c == C_NOP) continue;
         if (c == C_PALL) begin
            if (!a[10]) code = 3'd6;
            else if (!in_ref && i < PWR) code = 3'd1;
            else begin in_ref = 1; nref = 0; t_pall = i; t_ref = -1; end
         end else if (c == C_REF) begin
            if (!in_ref) code = 3'd6;
            else if (t_ref < 0 && i - t_pall < TRP) code = 3'd2;
            else if (t_ref >= 0 && i - t_ref < TRC) code = 3'd3;
            else begin nref++; t_ref = i; end
         end else if (c == C_MRS) begin
            if (!in_ref) code = 3'd6;
            else if (nref < NREF) code = 3'd4;
            else if (i - t_ref < TRC) code = 3'd3;
            else if (!(seq[i].ba == 2'd0 && a[12:10] == 3'd0 && a[8:7] == 2'd0 &&
                       (a[6:4] == 3'd2 || a[6:4] == 3'd3))) code = 3'd5;
            else begin done = 1; mode = a; end
         end else begin
            code = 3'd6;
         end
      end
      return mk(done, code != 3'd0, code, mode, (nref > 15) ? 15 : nref);
   endfunction

   task automatic test_reset();
      logic [24:0] e;
      bus.dram_cs_n = 1'b0; bus.dram_ras_n = 1'b0; bus.dram_cas_n = 1'b0; bus.dram_we_n = 1'b0;
      bus.dram_addr = 13'($urandom); bus.dram_ba = 2'($urandom);
      #3 reset = 1'b0;
      repeat (3) @(negedge clock);
      e = mk(0, 0, 0, 0, 0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL reset_state: got %h expected %h", obs(), e); end
   endtask

   task automatic test_legal();
      logic [24:0] e;
      apply_reset();
      legal_prefix(8);
      push(C_MRS, 13'h230, 2'd0);
      drive_seq();
      e = mk(0, 0, 0, 0, 8);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL legal_latency: got %h expected %h", obs(), e); end
      idle(1);
      e = mk(1, 0, 0, 13'h230, 8);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL legal_done: got %h expected %h", obs(), e); end
      push(C_ACT, 13'h0, 2'd1);
      push(C_REF, 13'h0, 2'd0);
      push(C_PALL, 13'h0, 2'd0);
      push(C_MRS, 13'h1FFF, 2'd3);
      drive_seq();
      idle(2);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL done_ignores: got %h expected %h", obs(), e); end
   endtask

   task automatic test_early_pall();
      logic [24:0] e;
      apply_reset();
      push_nops(PWR - 1);
      push(C_PALL, 13'h400, 2'd0);
      drive_seq();
      idle(1);
      e = mk(0, 1, 1, 0, 0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL early_pall: got %h expected %h", obs(), e); end
      push_nops(2);
      for (int r = 0; r < 8; r++) begin push(C_REF, 13'h0, 2'd0); push_nops(9); end
      push(C_MRS, 13'h230, 2'd0);
      drive_seq();
      idle(2);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL early_pall_sticky: got %h expected %h", obs(), e); end
   endtask

   task automatic test_trp();
      logic [24:0] e;
      apply_reset();
      push_nops(PWR);
      push(C_PALL, 13'h400, 2'd0);
      push(C_REF, 13'h0, 2'd0);
      drive_seq();
      idle(2);
      e = mk(0, 1, 2, 0, 0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL trp_k1: got %h expected %h", obs(), e); end
   endtask

   task automatic test_trc();
      logic [24:0] e;
      apply_reset();
      push_nops(PWR);
      push(C_PALL, 13'h400, 2'd0);
      push_nops(2);
      push(C_REF, 13'h0, 2'd0);
      push_nops(8);
      push(C_REF, 13'h0, 2'd0);
      drive_seq();
      idle(2);
      e = mk(0, 0, 0, 0, 2);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL trc_k9_ok: got %h expected %h", obs(), e); end
      push_nops(5);
      push(C_REF, 13'h0, 2'd0);
      drive_seq();
      idle(2);
      e = mk(0, 1, 3, 0, 2);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL trc_k8: got %h expected %h", obs(), e); end
   endtask

   task automatic test_mrs_errors();
      logic [24:0] e;
      apply_reset();
      legal_prefix(7);
      push(C_MRS, 13'h230, 2'd0);
      drive_seq();
      idle(2);
      e = mk(0, 1, 4, 0, 7);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL few_refs: got %h expected %h", obs(), e); end
      apply_reset();
      legal_prefix(8);
      push(C_MRS, 13'h210, 2'd0);
      drive_seq();
      idle(2);
      e = mk(0, 1, 5, 0, 8);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL bad_mode: got %h expected %h", obs(), e); end
   endtask

   task automatic test_illegal_cmd();
      logic [24:0] e;
      apply_reset();
      push_nops(PWR);
      push(C_PALL, 13'h400, 2'd0);
      push_nops(2);
      push(C_ACT, 13'h123, 2'd1);
      drive_seq();
      idle(2);
      e = mk(0, 1, 6, 0, 0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL act_in_wait_ref: got %h expected %h", obs(), e); end
      apply_reset();
      push_nops(PWR + 3);
      push(C_PALL, 13'h000, 2'd0);
      drive_seq();
      idle(2);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL pall_a10_low: got %h expected %h", obs(), e); end
   endtask

   task automatic test_async_reset();
      logic [24:0] e;
      apply_reset();
      legal_prefix(4);
      drive_seq();
      e = mk(0, 0, 0, 0, 4);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL before_midreset: got %h expected %h", obs(), e); end
      reset = 1'b0;
      #1;
      e = mk(0, 0, 0, 0, 0);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL async_clear: got %h expected %h", obs(), e); end
      apply_reset();
      legal_prefix(8);
      push(C_MRS, 13'h230, 2'd0);
      drive_seq();
      idle(2);
      e = mk(1, 0, 0, 13'h230, 8);
      total++;
      if (obs() !== e) begin bad++; $display("FAIL rerun_after_reset: got %h expected %h", obs(), e); end
   endtask

   task automatic test_random();
      logic [24:0] e;
      logic [12:0] a;
      int          nrefs;
      for (int it = 0; it < 30; it++) begin
         apply_reset();
         push_idle_rand(PWR - 2 + $urandom_range(0, 4));
         push(C_PALL, ($urandom_range(0, 7) == 0) ? 13'h000 : 13'h400 | 13'($urandom), 2'($urandom));
         push_idle_rand($urandom_range(0, 3));
         nrefs = $urandom_range(6, 10);
         for (int r = 0; r < nrefs; r++) begin
            if ($urandom_range(0, 11) == 0) begin
               push(C_PALL, ($urandom_range(0, 5) == 0) ? 13'h000 : 13'h400, 2'd0);
               push_idle_rand($urandom_range(0, 3));
            end
            push(C_REF, 13'($urandom), 2'($urandom));
            if ($urandom_range(0, 24) == 0) push({1'b0, 3'($urandom_range(3, 6))}, 13'($urandom), 2'd0);
            push_idle_rand(($urandom_range(0, 15) == 0) ? 7 : $urandom_range(8, 11));
         end
         if ($urandom_range(0, 1) == 0) begin
            a = 13'($urandom);
            a[12:10] = 3'd0;
            a[8:7]   = 2'd0;
            a[6:4]   = 3'($urandom_range(2, 3));
            push(C_MRS, a, 2'd0);
         end else begin
            push(C_MRS, 13'($urandom), 2'($urandom));
         end
         for (int t = 0; t < 3; t++) push({1'b0, 3'($urandom)}, 13'($urandom), 2'($urandom));
         e = model();
         drive_seq();
         idle(2);
         total++;
         if (obs() !== e) begin bad++; $display("FAIL random_run%0d: got %h expected %h", it, obs(), e); end
      end
   endtask

   initial begin
      test_reset();
      test_legal();
      test_early_pall();
      test_trp();
      test_trc();
      test_mrs_errors();
      test_illegal_cmd();
      test_async_reset();
      test_random();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end
endmodule

// File: doc/sdram_init_monitor.md
Name: sdram_init_monitor

Overview:
- Passive protocol checker on the DE10-Lite SDRAM command bus: the observing end of the SDRAM initialization sequence.
- Samples CS/RAS/CAS/WE, address and bank pins every clock (200 MHz).
- Checks the power-up wait, precharge-all, auto-refresh burst and Mode Register Set for order and minimum spacing.
- Reports completion, the programmed mode word and the first violation. Sits beside the SDRAM pins in simulation and on-chip debug; never drives the bus.

Parameters:
POWER_UP_CYCLES, 20000, minimum cycles from reset release to PALL (100 us)
TRP_CYCLES, 2, minimum edges from PALL to first REF
TRC_CYCLES, 9, minimum edges REF->REF and last REF->MRS
REFRESH_COUNT, 8, minimum REF commands before MRS

Ports:
clock  in  1  system clock, 200 MHz
reset  in  1  asynchronous, active-low reset
dram_cs_n  in  1  chip select, active-low
dram_ras_n  in  1  row address strobe, active-low
dram_cas_n  in  1  column address strobe, active-low
dram_we_n  in  1  write enable, active-low
dram_addr  in  13  address pins A12..A0
dram_ba  in  2  bank address
init_done  out  1  legal init sequence completed (sticky)
error  out  1  violation detected (sticky)
error_code  out  3  code of the first violation
mode_reg  out  13  address word captured at a legal MRS
cas_latency  out  3  mode_reg[6:4]
refresh_count  out  4  REFs seen since PALL, saturates at 15

Behaviour:
- Reset (reset=0, asynchronous): all outputs 0, all counters 0, state WAIT_PWR.
- Command decode of {cs_n,ras_n,cas_n,we_n}:
  - 1xxx = DESELECT; 0111 = NOP.
  - 0010 = PALL; legal only with A10=1.
  - 0001 = REF; 0000 = MRS.
  - Any other value (ACT, READ, WRITE, BST) is illegal before init_done.
- Counters:
  - pwr_cnt: 15 bits, increments every edge after reset release, saturates at POWER_UP_CYCLES.
  - gap_cnt: 8 bits, cleared on the edge that samples PALL or REF, then increments, saturates at 255. The spacing k between two commands is gap_cnt+1 at the later edge.
- States:
  - WAIT_PWR: NOP/DESELECT allowed. A PALL sampled when pwr_cnt >= POWER_UP_CYCLES goes to WAIT_REF. An early PALL gives code 1.
  - WAIT_REF: NOP/DESELECT allowed.
    - REF with k >= TRP_CYCLES (from PALL) or k >= TRC_CYCLES (from the previous REF) increments refresh_count and stays.
    - Early REF after PALL gives code 2; early REF after REF gives code 3.
    - MRS handling:
      - refresh_count < REFRESH_COUNT gives code 4.
      - Otherwise k < TRC_CYCLES gives code 3.
      - Otherwise a bad mode word gives code 5.
      - Otherwise go to DONE.
    - A repeated PALL is legal: it restarts the refresh phase (refresh_count=0, gap cleared).
  - Mode word legality: dram_ba=0, A12..A10=0, A8..A7=0, A6..A4 in {2,3}. A9, A3 and A2..A0 are unchecked.
  - DONE: init_done=1, mode_reg and cas_latency held. All later commands are ignored; no further checks.
  - ERROR: error=1 and error_code frozen at the first violation until reset. Other outputs freeze.
- Error codes:
  - 0 none, 1 early PALL, 2 tRP violation, 3 tRC violation, 4 too few REFs, 5 bad mode word.
  - 6 illegal command for state: REF or MRS in WAIT_PWR, PALL with A10=0, ACT/READ/WRITE/BST before DONE.
- Latency: all outputs are registered and update on the edge after the edge that samples the command.
- Priority: an error always beats a state transition. When one command breaks several rules, the code is chosen by the check order above.
- Reset mid-sequence: everything restarts, including the power-up wait.

Test Plan:
- Legal run: 20000 NOPs, PALL(A10=1), 2 NOPs, 8x(REF + 9 NOPs), MRS addr=0x230 ba=0 -> one cycle after MRS: init_done=1, mode_reg=0x230, cas_latency=3, refresh_count=8, error=0.
- PALL sampled at pwr_cnt=19999 -> error=1, error_code=1 next cycle. A following legal sequence leaves init_done=0 and error_code=1.
- PALL then REF on the very next edge (k=1) -> error_code=2. Separate run: REF,8 NOPs,REF (k=9) passes, REF,7 NOPs,REF (k=8) -> error_code=3.
- MRS after only 7 legal REFs -> error_code=4. Separate run: 8 REFs then MRS addr=0x210 (CAS=1) -> error_code=5, mode_reg stays 0.
- ACT (0011) during WAIT_REF -> error_code=6. PALL with A10=0 after power-up -> error_code=6.
- Drop reset to 0 after the 4th REF -> outputs 0 immediately (asynchronous). After release, a full legal run from 20000 NOPs -> init_done=1, refresh_count=8.
